// File: rtl/utim64_host_bridge.sv
// UTIM64 host bridge: turns 32/64-bit CPU register commands into single-word
// device requests and assembles in-order read responses, with a response timeout.
module utim64_host_bridge #(
    parameter int P_TIMEOUT   = 1024,
    parameter int P_DISCARD_W = 4
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    input  logic        iCMD_VALID,
    output logic        oCMD_BUSY,
    input  logic        iCMD_RW,
    input  logic        iCMD_WIDE,
    input  logic [3:0]  iCMD_ADDR,
    input  logic [63:0] iCMD_DATA,
    output logic        oRSP_VALID,
    output logic        oRSP_ERROR,
    output logic [63:0] oRSP_DATA,
    output logic        oSPURIOUS,
    output logic        oDEV_REQ_VALID,
    input  logic        iDEV_REQ_BUSY,
    output logic        oDEV_REQ_RW,
    output logic [3:0]  oDEV_REQ_ADDR,
    output logic [31:0] oDEV_REQ_DATA,
    input  logic        iDEV_REQ_VALID,
    input  logic [31:0] iDEV_REQ_DATA
);

    localparam int TMO_W  = $clog2(P_TIMEOUT + 1);
    localparam int DSUM_W = P_DISCARD_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_SEND0, S_SEND1, S_WAIT, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic                   rw_q, wide_q, err_q, spurious_q;
    logic [3:0]             addr_q;
    logic [63:0]            cmd_data_q, rsp_data_q;
    logic [1:0]             exp_q, rcv_q;
    logic [TMO_W-1:0]       tmo_q;
    logic [P_DISCARD_W-1:0] discard_q, discard_sat;
    logic [DSUM_W-1:0]      discard_sum;

    logic cmd_accept, wide_legal, dev_xfer, rsp_accept, rsp_late, rsp_spurious, timeout;

    assign cmd_accept   = iCMD_VALID && (state_q == S_IDLE);
    assign wide_legal   = iCMD_ADDR inside {4'd1, 4'd3, 4'd5, 4'd7, 4'd9};
    assign dev_xfer     = ((state_q == S_SEND0) || (state_q == S_SEND1)) && !iDEV_REQ_BUSY;
    // Only one word is in flight during SEND1, so at most the first response is expected there.
    assign rsp_accept   = iDEV_REQ_VALID && !rw_q &&
                          (((state_q == S_SEND1) && (rcv_q == 2'd0)) ||
                           ((state_q == S_WAIT) && (rcv_q < exp_q)));
    assign rsp_late     = iDEV_REQ_VALID && !rsp_accept && (discard_q != '0);
    assign rsp_spurious = iDEV_REQ_VALID && !rsp_accept && (discard_q == '0);
    assign timeout      = (state_q == S_WAIT) && !rsp_accept && (tmo_q == TMO_W'(P_TIMEOUT - 1));

    assign discard_sum  = DSUM_W'(discard_q) + DSUM_W'(exp_q - rcv_q);
    assign discard_sat  = discard_sum[P_DISCARD_W] ? '1 : discard_sum[P_DISCARD_W-1:0];

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_accept) state_d = (iCMD_WIDE && !wide_legal) ? S_DONE : S_SEND0;
            S_SEND0: if (dev_xfer)   state_d = wide_q ? S_SEND1 : (rw_q ? S_DONE : S_WAIT);
            S_SEND1: if (dev_xfer)   state_d = rw_q ? S_DONE : S_WAIT;
            S_WAIT:  if ((rsp_accept && (rcv_q + 2'd1 == exp_q)) || timeout) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: request valid is combinational on busy so a busy cycle never counts as a transfer.
    always_comb begin
        oCMD_BUSY      = (state_q != S_IDLE);
        oDEV_REQ_VALID = dev_xfer;
        oDEV_REQ_RW    = 1'b0;
        oDEV_REQ_ADDR  = '0;
        oDEV_REQ_DATA  = '0;
        if (state_q == S_SEND0) begin
            oDEV_REQ_RW   = rw_q;
            oDEV_REQ_ADDR = addr_q;
            oDEV_REQ_DATA = wide_q ? cmd_data_q[63:32] : cmd_data_q[31:0];
        end else if (state_q == S_SEND1) begin
            oDEV_REQ_RW   = rw_q;
            oDEV_REQ_ADDR = addr_q + 4'd1;
            oDEV_REQ_DATA = cmd_data_q[31:0];
        end
        oRSP_VALID = (state_q == S_DONE);
        oRSP_ERROR = (state_q == S_DONE) && err_q;
        oRSP_DATA  = (state_q == S_DONE) ? rsp_data_q : '0;
        oSPURIOUS  = spurious_q;
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            rw_q       <= 1'b0;
            wide_q     <= 1'b0;
            addr_q     <= '0;
            cmd_data_q <= '0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
            exp_q      <= '0;
            rcv_q      <= '0;
            tmo_q      <= '0;
            discard_q  <= '0;
            spurious_q <= 1'b0;
        end else begin
            spurious_q <= rsp_spurious;
            if (cmd_accept) begin
                rw_q       <= iCMD_RW;
                wide_q     <= iCMD_WIDE;
                addr_q     <= iCMD_ADDR;
                cmd_data_q <= iCMD_DATA;
                rsp_data_q <= '0;
                err_q      <= iCMD_WIDE && !wide_legal;
                exp_q      <= iCMD_RW ? 2'd0 : (iCMD_WIDE ? 2'd2 : 2'd1);
                rcv_q      <= '0;
                tmo_q      <= '0;
            end
            if (rsp_accept) begin
                rcv_q <= rcv_q + 2'd1;
                tmo_q <= '0;
                if (wide_q && (rcv_q == 2'd0)) rsp_data_q[63:32] <= iDEV_REQ_DATA;
                else                           rsp_data_q[31:0]  <= iDEV_REQ_DATA;
            end else if (state_q == S_WAIT) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end
            // Words still owed by the device on timeout will arrive later and must be swallowed.
            if (timeout) begin
                err_q      <= 1'b1;
                rsp_data_q <= '0;
                discard_q  <= discard_sat;
            end else if (rsp_late) begin
                discard_q <= discard_q - 1'b1;
            end
        end
    end

endmodule
